// File: rtl/double_pulse_generator_pkg.sv
// Shared types and effective-parameter arithmetic for the double-pulse stimulus source.
// Clamping guarantees at least one low cycle between pulses and between events.
package double_pulse_gen_pkg;

  localparam int DPG_CNT_W = 16;
  localparam int DPG_PER_W = 32;

  localparam logic [DPG_CNT_W:0] C_ONE = {{DPG_CNT_W{1'b0}}, 1'b1};
  localparam logic [DPG_PER_W:0] P_ONE = {{DPG_PER_W{1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, P1, GAP, P2, WAIT} state_e;

  typedef struct packed {
    logic [DPG_CNT_W:0] w;
    logic [DPG_CNT_W:0] d;
    logic [DPG_PER_W:0] p;
  } eff_t;

  function automatic eff_t calc_eff(
    input logic [DPG_CNT_W-1:0] width,
    input logic [DPG_CNT_W-1:0] delay,
    input logic [DPG_PER_W-1:0] period,
    input logic                 single
  );
    eff_t               e;
    logic [DPG_CNT_W:0] wx;
    logic [DPG_CNT_W:0] dx;
    logic [DPG_PER_W:0] px;
    logic [DPG_PER_W:0] floor_p;
    wx = (width == '0) ? C_ONE : {1'b0, width};
    dx = ({1'b0, delay} > wx) ? {1'b0, delay} : (wx + C_ONE);
    px = {1'b0, period};
    // Single-pulse events never use D, so the period floor only covers the first pulse.
    if (single)
      floor_p = {{(DPG_PER_W-DPG_CNT_W){1'b0}}, wx} + P_ONE;
    else
      floor_p = {{(DPG_PER_W-DPG_CNT_W){1'b0}}, dx} + {{(DPG_PER_W-DPG_CNT_W){1'b0}}, wx} + P_ONE;
    e.w = wx;
    e.d = dx;
    e.p = (px >= floor_p) ? px : floor_p;
    return e;
  endfunction

endpackage

// File: rtl/double_pulse_generator.sv
// Programmable double-pulse trigger source: first pulse, second pulse after D, events every P.
// First rise one cycle after an accepted start; all outputs registered, no backpressure.
module double_pulse_generator
  import double_pulse_gen_pkg::*;
#(
  parameter int CNT_W = DPG_CNT_W,
  parameter int PER_W = DPG_PER_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             single,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] delay,
  input  logic [PER_W-1:0] period,
  input  logic [CNT_W-1:0] n_events,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] event_count
);

  localparam logic [PER_W:0]   X_ONE   = {{PER_W{1'b0}}, 1'b1};
  localparam logic [PER_W-1:0] PH_ONE  = {{(PER_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic             r_pulse_out;
  logic             r_busy;
  logic             r_done;
  logic             r_single;
  logic [CNT_W-1:0] r_event_count;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W:0]   r_w;
  logic [CNT_W:0]   r_d;
  logic [PER_W:0]   r_p;
  logic [PER_W-1:0] r_phase;

  eff_t           w_eff;
  logic [PER_W:0] w_ph;
  logic [PER_W:0] w_w;
  logic [PER_W:0] w_d;
  logic           w_p1_end;
  logic           w_gap_end;
  logic           w_p2_end;
  logic           w_wait_end;
  logic           w_last;

  assign w_eff = calc_eff(width, delay, period, single);

  // Phase is measured from the current event's first rise; every boundary is a compare on it.
  assign w_ph       = {1'b0, r_phase};
  assign w_w        = {{(PER_W-CNT_W){1'b0}}, r_w};
  assign w_d        = {{(PER_W-CNT_W){1'b0}}, r_d};
  assign w_p1_end   = (w_ph == (w_w - X_ONE));
  assign w_gap_end  = (w_ph == (w_d - X_ONE));
  assign w_p2_end   = (w_ph == (w_d + w_w - X_ONE));
  assign w_wait_end = (w_ph == (r_p - X_ONE));
  assign w_last     = (r_n != '0) && (r_event_count == r_n);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_pulse_out   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_single      <= 1'b0;
      r_event_count <= '0;
      r_n           <= '0;
      r_w           <= '0;
      r_d           <= '0;
      r_p           <= '0;
      r_phase       <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != IDLE && abort) begin
        r_state     <= IDLE;
        r_pulse_out <= 1'b0;
        r_busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !abort) begin
              r_w           <= w_eff.w;
              r_d           <= w_eff.d;
              r_p           <= w_eff.p;
              r_single      <= single;
              r_n           <= n_events;
              r_event_count <= CNT_ONE;
              r_phase       <= '0;
              r_state       <= P1;
              r_pulse_out   <= 1'b1;
              r_busy        <= 1'b1;
            end
          end
          P1: begin
            r_phase <= r_phase + PH_ONE;
            if (w_p1_end) begin
              r_pulse_out <= 1'b0;
              if (!r_single) begin
                r_state <= GAP;
              end else if (w_last) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= WAIT;
              end
            end
          end
          GAP: begin
            r_phase <= r_phase + PH_ONE;
            if (w_gap_end) begin
              r_state     <= P2;
              r_pulse_out <= 1'b1;
            end
          end
          P2: begin
            r_phase <= r_phase + PH_ONE;
            if (w_p2_end) begin
              r_pulse_out <= 1'b0;
              if (w_last) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= WAIT;
              end
            end
          end
          WAIT: begin
            if (w_wait_end) begin
              r_phase       <= '0;
              r_state       <= P1;
              r_pulse_out   <= 1'b1;
              r_event_count <= r_event_count + CNT_ONE;
            end else begin
              r_phase <= r_phase + PH_ONE;
            end
          end
          default: begin
            r_state     <= IDLE;
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse_out   = r_pulse_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign event_count = r_event_count;

endmodule

// File: tb/tb_double_pulse_generator.sv
// Scoreboard bench: expected edges/done strobes come from a cycle-level waveform model.
// Stimulus pushes expectations; the negedge monitor pops and compares what the DUT emits.
module tb_double_pulse_generator;
  import double_pulse_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start, abort, single;
  logic [15:0] width, delay, n_events;
  logic [31:0] period;
  logic        pulse_out, busy, done;
  logic [15:0] event_count;

  double_pulse_generator dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .single(single),
    .width(width), .delay(delay), .period(period), .n_events(n_events),
    .pulse_out(pulse_out), .busy(busy), .done(done), .event_count(event_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int kind; int cyc; int val; } txn_t;   // kind: 0 rise, 1 fall, 2 done
  typedef struct { int t; int w; int d; int p; int n; bit sgl; int a; } burst_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  logic prev_pulse = 1'b0;

  task automatic check(input bit ok, input string name, input int got, input int want);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic observe(input int kind);
    txn_t e;
    if (exp_q.size() == 0) begin
      check(1'b0, "unexpected_output_kind", kind, -1);
      return;
    end
    e = exp_q.pop_front();
    check(e.kind == kind, "txn_kind", kind, e.kind);
    check(e.cyc == cyc, "txn_cycle", cyc, e.cyc);
    if (kind == 0) check(busy === 1'b1, "busy_at_rise", int'(busy), 1);
    if (kind == 2) begin
      check(busy === 1'b0, "busy_at_done", int'(busy), 0);
      check(int'(event_count) == e.val, "count_at_done", int'(event_count), e.val);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (pulse_out !== prev_pulse) begin
        observe(pulse_out ? 0 : 1);
        prev_pulse = pulse_out;
      end
      if (done === 1'b1) observe(2);
    end
  end

  // Expected level of the trigger line in cycle c for a burst.
  function automatic bit exp_hi(input burst_t b, input int c);
    int off, k, ph;
    if (c < b.t + 1 || c > b.a) return 1'b0;
    off = c - (b.t + 1);
    k   = off / b.p;
    ph  = off % b.p;
    if (b.n != 0 && k >= b.n) return 1'b0;
    return (ph < b.w) || (!b.sgl && ph >= b.d && ph < b.d + b.w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called with the current cycle being the start cycle; returns in the done/abort+1 cycle.
  task automatic run_burst(input int w, input int d, input int p, input int n,
                           input bit sgl, input int abort_off, input bit interfere);
    burst_t b;
    eff_t   e;
    txn_t   x;
    int     t, rw, rd, rp, last_hi, done_c, endc, rises, exp_cnt;
    t = cyc;
    width = 16'(w); delay = 16'(d); period = 32'(p); n_events = 16'(n); single = sgl;
    start = 1'b1; abort = 1'b0;
    rw = (w == 0) ? 1 : w;
    rd = (d >= rw + 1) ? d : rw + 1;
    if (sgl) rp = (p >= rw + 1) ? p : rw + 1;
    else     rp = (p >= rd + rw + 1) ? p : rd + rw + 1;
    e = calc_eff(width, delay, period, single);
    check(int'(e.w) == rw && (sgl || int'(e.d) == rd) && int'(e.p) == rp,
          "calc_eff_P", int'(e.p), rp);
    b = '{t: t, w: rw, d: rd, p: rp, n: n, sgl: sgl,
          a: (abort_off == 0) ? 32'h3fff_ffff : t + abort_off};
    last_hi = (n != 0) ? t + 1 + (n - 1) * rp + (sgl ? rw - 1 : rd + rw - 1) : 32'h3fff_ffff;
    done_c  = (n != 0 && b.a > last_hi) ? last_hi + 1 : -1;
    endc    = (done_c >= 0) ? done_c : b.a + 1;
    for (int c = t + 1; c <= endc; c++) begin
      if (exp_hi(b, c) != exp_hi(b, c - 1)) begin
        x = '{kind: exp_hi(b, c) ? 0 : 1, cyc: c, val: 0};
        exp_q.push_back(x);
      end
    end
    if (done_c >= 0) begin
      x = '{kind: 2, cyc: done_c, val: n};
      exp_q.push_back(x);
    end
    for (int c = t + 1; c <= endc; c++) begin
      tick();
      start  = interfere && (c < endc) && ($urandom_range(0, 5) == 0);
      abort  = (c == b.a);
      width  = 16'($urandom_range(0, 30));
      delay  = 16'($urandom_range(0, 30));
      period = 32'($urandom_range(0, 90));
      single = 1'($urandom_range(0, 1));
    end
    if (done_c < 0) begin
      rises   = (b.a - (t + 1)) / rp + 1;
      exp_cnt = (n != 0 && rises > n) ? n : rises;
      @(negedge clk);
      check(busy === 1'b0, "busy_after_abort", int'(busy), 0);
      check(pulse_out === 1'b0, "pulse_after_abort", int'(pulse_out), 0);
      check(int'(event_count) == exp_cnt, "count_after_abort", int'(event_count), exp_cnt);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int w, d, p, n, ab;
    bit sgl;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; single = 1'b0;
    width = '0; delay = '0; period = '0; n_events = '0;
    repeat (3) tick();
    check(pulse_out === 1'b0, "reset_pulse_out", int'(pulse_out), 0);
    check(busy === 1'b0, "reset_busy", int'(busy), 0);
    check(done === 1'b0, "reset_done", int'(done), 0);
    check(event_count === 16'd0, "reset_event_count", int'(event_count), 0);
    rstn = 1'b1;
    tick();
    mon_en = 1'b1;

    run_burst(4, 20, 100, 3, 1'b0, 0, 1'b1);
    repeat (3) tick();
    run_burst(10, 5, 40, 2, 1'b0, 0, 1'b0);
    run_burst(2, 0, 3, 2, 1'b1, 0, 1'b0);          // start in the done cycle
    repeat (2) tick();
    run_burst(4, 20, 50, 0, 1'b0, 972, 1'b1);       // continuous, abort in event 19's second pulse
    repeat (2) tick();
    run_burst(0, 0, 0, 2, 1'b0, 0, 1'b0);

    // start together with abort while idle must do nothing
    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check(busy === 1'b0, "start_abort_idle_busy", int'(busy), 0);

    for (int i = 0; i < 30; i++) begin
      w   = $urandom_range(0, 8);
      d   = $urandom_range(0, 24);
      p   = $urandom_range(0, 70);
      n   = $urandom_range(0, 4);
      sgl = 1'($urandom_range(0, 3) == 0);
      ab  = 0;
      if (n == 0 || $urandom_range(0, 3) == 0) ab = $urandom_range(1, 250);
      run_burst(w, d, p, n, sgl, ab, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 4)) tick();
    end

    repeat (5) tick();
    check(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a pulse
    mon_en = 1'b0;
    width = 16'd40; delay = 16'd0; period = 32'd0; n_events = 16'd1; single = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check(pulse_out === 1'b1, "pulse_before_reset", int'(pulse_out), 1);
    #2 rstn = 1'b0;
    #1;
    check(pulse_out === 1'b0, "async_reset_pulse", int'(pulse_out), 0);
    check(busy === 1'b0, "async_reset_busy", int'(busy), 0);
    tick();
    rstn = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/double_pulse_generator.md
# double_pulse_generator

- Programmable double-pulse stimulus source for the muon-decay trigger path.
- Each event is a first pulse, then a second pulse after a programmed rising-to-rising delay. This emulates a muon stop followed by its decay electron.
- Drives the same single-bit trigger line that the double-pulse detector samples. Used for closed-loop FPGA self-test of coincidence-window settings and for bench verification of the detector.
- Bursts can be a fixed event count or continuous; events are spaced by a programmable period.

## Interface
- CNT_W, 16: width of width/delay/event-count fields.
- PER_W, 32: width of period field.
- clk  in  1  single clock; all logic rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; ignored while busy.
- abort  in  1  terminate burst immediately; has priority over start.
- single  in  1  1 = suppress second pulse (single-pulse events, for negative testing).
- width  in  CNT_W  pulse high time, cycles; 0 treated as 1.
- delay  in  CNT_W  first-rise to second-rise, cycles.
- period  in  PER_W  first-rise to next event's first-rise, cycles.
- n_events  in  CNT_W  events per burst; 0 = continuous until abort.
- pulse_out  out  1  registered trigger output.
- busy  out  1  burst in progress.
- done  out  1  one-cycle strobe at normal burst completion.
- event_count  out  CNT_W  first pulses emitted in current/last burst.

## Operation
- Configuration inputs latch on an accepted start and are held for the whole burst. Changes mid-burst have no effect.
- Effective values are computed at latch with CNT_W+1 / PER_W+1 bit arithmetic, so there is no overflow:
  - W = max(width,1).
  - D = max(delay, W+1). This guarantees at least one low cycle between pulses.
  - P = max(period, D+W+1).
  - With single=1, D is unused and P = max(period, W+1).
- FSM states: IDLE, P1, GAP, P2, WAIT.
  - IDLE: on start & !abort, latch config, clear event_count, go to P1.
  - P1: pulse_out high for W cycles; event_count increments on entry. Then go to GAP, or to WAIT if single=1.
  - GAP: pulse_out low until the second rise at offset D from the first rise, then go to P2.
  - P2: pulse_out high for W cycles, then go to WAIT.
  - WAIT: pulse_out low until offset P, then go to P1.
- Burst end: if this was the last event (event_count == n_events, n_events ≠ 0), skip WAIT and return to IDLE after the event's final falling edge.
- A single phase counter (PER_W bits) is cleared at each first rise. It sequences every phase boundary.
- event_count wraps modulo 2^CNT_W in continuous mode. It holds its final value after done until the next accepted start.
- abort in any non-IDLE state: next cycle IDLE, pulse_out=0, busy=0, done stays 0. A partial pulse is truncated, not stretched.

## Timing
- Reset values: pulse_out=0, busy=0, done=0, event_count=0, state IDLE. Reset mid-burst drops pulse_out asynchronously.
- Start accepted at cycle t:
  - First pulse: busy=1 and pulse_out=1 from t+1, high cycles t+1..t+W.
  - Second pulse: high cycles t+1+D..t+D+W.
  - Event k (k from 0): first rise at t+1+k·P.
- Completion after the last event's final high cycle c: in cycle c+1, pulse_out=0, busy=0, done=1 (one cycle).
- A start coinciding with the done cycle is accepted; the new first rise comes one cycle later.
- abort and start in the same IDLE cycle: nothing happens.
- Latency, start to first edge: 1 cycle fixed. No combinational path from any input to pulse_out.

## Structure
- Package double_pulse_gen_pkg holds:
  - the state enum (IDLE, P1, GAP, P2, WAIT);
  - default CNT_W/PER_W constants;
  - a function computing effective W/D/P from raw inputs, reused by the testbench scoreboard.
- No sub-module: one FSM plus phase counter, event counter and latched config registers.

## Test plan
- width=4, delay=20, period=100, n_events=3, start at t → rises at t+1, t+21, t+101, t+121, t+201, t+221; each 4 cycles high; done at t+225; event_count=3.
- width=10, delay=5 → D clamped to 11: second rise at t+12, one low cycle at t+11.
- single=1, width=2, period=3, n_events=2 → rises at t+1, t+4 only; done at t+6.
- n_events=0, period=50: run 1000 cycles, then abort during a pulse → pulse_out=0 and busy=0 next cycle; done never asserted; event_count=20.
- start during busy and width changed mid-burst → ignored; pulse shape unchanged. Simultaneous start+abort in IDLE → busy stays 0.
- Closed loop into the double-pulse detector (detector window=200): delay=150 → double_trig=1 on second pulse; delay=250 → double_trig=0.
